// File: rtl/shared_reg_arb_pkg.sv
// Shared types and width helpers for the round-robin shared-register arbiter.
package shared_reg_arb_pkg;

  typedef enum logic {IDLE, OWNED} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int hold_w(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan from the far end back toward ptr so the closest set bit is written last.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared W-bit register.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4,
  localparam int IW      = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  wr_en,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]  gnt,
  output logic [W-1:0]  q,
  output logic [IW-1:0] q_owner,
  output logic          q_upd
);

  localparam int HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]  gnt_nxt;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          rel;
  logic          wr_hit;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Owner dropping req and timer expiry on the same edge collapse into one release.
  always_comb rel = !req[owner] || (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nxt   = N'(1) << pick_idx;
          owner_nxt = pick_idx;
          hold_nxt  = '0;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        hold_nxt = hold_cnt + HW'(1);
        if (rel) begin
          gnt_nxt   = '0;
          ptr_nxt   = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // gnt is one-hot, so at most one lane can hit; the registered gnt gates the write.
  always_comb begin
    wr_hit  = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && wr_en[i]) begin
        wr_hit  = 1'b1;
        wr_idx  = IW'(i);
        wr_data = wdata[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      q        <= '0;
      q_owner  <= '0;
      q_upd    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      q_upd    <= wr_hit;
      if (wr_hit) begin
        q       <= wr_data;
        q_owner <= wr_idx;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed scoreboard bench for shared_reg_arbiter with N=4, W=8, MAX_HOLD=4.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        q_upd;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] q;
    logic [1:0] o;
    logic       u;
    logic       c;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];
  int    n_cmp;
  int    n_err;

  shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_upd   (q_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                      input logic [1:0] eo, input logic eu, input logic cq);
    exp_t e;
    e.g = eg; e.q = eq; e.o = eo; e.u = eu; e.c = cq;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    e = expq.pop_front();
    t = tagq.pop_front();
    n_cmp++;
    assert (gnt === e.g) else begin
      n_err++;
      $error("FAIL %s gnt: got %b want %b", t, gnt, e.g);
    end
    if (e.c) begin
      n_cmp += 3;
      assert (q === e.q) else begin
        n_err++;
        $error("FAIL %s q: got %h want %h", t, q, e.q);
      end
      assert (q_owner === e.o) else begin
        n_err++;
        $error("FAIL %s q_owner: got %0d want %0d", t, q_owner, e.o);
      end
      assert (q_upd === e.u) else begin
        n_err++;
        $error("FAIL %s q_upd: got %b want %b", t, q_upd, e.u);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                         input logic [1:0] eo, input logic eu);
    push(tag, eg, eq, eo, eu, 1'b1);
    compare_out();
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] we, input logic [31:0] wd,
                      input string tag, input logic [3:0] eg, input logic [7:0] eq,
                      input logic [1:0] eo, input logic eu, input logic cq);
    @(negedge clk);
    req   = r;
    wr_en = we;
    wdata = wd;
    push(tag, eg, eq, eo, eu, cq);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    logic [7:0]  prev_q;
    logic [1:0]  prev_o;
    logic [31:0] wd;
    logic        gon, gb, upd;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    wr_en = '0;
    wdata = '0;
    #3;
    chk_now("reset_init", 4'b0000, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from IDLE, then a write by the owner.
    step(4'b0100, 4'b0000, 32'h0, "t2_grant", 4'b0100, 8'h00, 2'd0, 1'b0, 1'b1);
    step(4'b0100, 4'b0100, 32'h003C_0000, "t2_write", 4'b0100, 8'h3C, 2'd2, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, "t2_drop", 4'b0000, 8'h3C, 2'd2, 1'b0, 1'b1);

    // Async reset in the middle of a grant to requester 1 holding q=A5.
    step(4'b0010, 4'b0000, 32'h0, "t1_grant", 4'b0010, 8'h3C, 2'd2, 1'b0, 1'b1);
    step(4'b0010, 4'b0010, 32'h0000_A500, "t1_write", 4'b0010, 8'hA5, 2'd1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    req   = '0;
    wr_en = '0;
    #1;
    chk_now("t1_async_rst", 4'b0000, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters continuously asking; each writes its own index while granted.
    prev_q = 8'h00;
    prev_o = 2'd0;
    for (int g = 0; g < 5; g++) begin
      int i;
      i = g % 4;
      step(4'b1111, 4'b1111, 32'h0302_0100, "t3_rr_grant", 4'(1 << i), prev_q, prev_o, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++)
        step(4'b1111, 4'b1111, 32'h0302_0100, "t3_rr_hold", 4'(1 << i), 8'(i), 2'(i), 1'b1, 1'b1);
      step(4'b1111, 4'b1111, 32'h0302_0100, "t3_rr_release", 4'b0000, 8'(i), 2'(i), 1'b1, 1'b1);
      prev_q = 8'(i);
      prev_o = 2'(i);
    end

    // Non-granted write strobe is ignored.
    step(4'b0001, 4'b0000, 32'h0, "t4_grant", 4'b0001, 8'h00, 2'd0, 1'b0, 1'b1);
    step(4'b0001, 4'b0001, 32'h0000_005A, "t4_owner_wr", 4'b0001, 8'h5A, 2'd0, 1'b1, 1'b1);
    step(4'b0001, 4'b0010, 32'hFFFF_FFFF, "t4_foreign_wr", 4'b0001, 8'h5A, 2'd0, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, "t4_release", 4'b0000, 8'h5A, 2'd0, 1'b0, 1'b1);

    // Early drop by owner 2, then waiting req[3] beats req[0] on the advanced pointer.
    step(4'b0100, 4'b0000, 32'h0, "t5_grant2", 4'b0100, 8'h5A, 2'd0, 1'b0, 1'b1);
    step(4'b1101, 4'b0000, 32'h0, "t5_hold2", 4'b0100, 8'h5A, 2'd0, 1'b0, 1'b1);
    step(4'b1001, 4'b0000, 32'h0, "t5_drop2", 4'b0000, 8'h5A, 2'd0, 1'b0, 1'b1);
    step(4'b1001, 4'b0000, 32'h0, "t5_grant3", 4'b1000, 8'h5A, 2'd0, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, "t5_release3", 4'b0000, 8'h5A, 2'd0, 1'b0, 1'b1);

    // Sole requester 1 for 12 cycles, writing only on odd steps.
    prev_q = 8'h5A;
    prev_o = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      gon = (k % 5) != 0;
      gb  = (k == 1) ? 1'b0 : (((k - 1) % 5) != 0);
      upd = gb && (k % 2 == 1);
      wd  = '0;
      wd[15:8] = 8'(16 + k);
      if (upd) begin
        prev_q = 8'(16 + k);
        prev_o = 2'd1;
      end
      step(4'b0010, (k % 2 == 1) ? 4'b0010 : 4'b0000, wd, "t6_sole",
           gon ? 4'b0010 : 4'b0000, prev_q, prev_o, upd, 1'b1);
    end
    step(4'b0000, 4'b0000, 32'h0, "t6_final", 4'b0000, 8'h19, 2'd1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
